// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing and hazard controller for the 5-stage 8-bit pipeline.
// Starts execution, inserts load-use bubbles, flushes on taken branches and
// drains the pipe after HALT before reporting completion.
// Build option: define PIPE_PERF_CNT_EN to get live stall/flush perf counters;
// without it the counters have no flops and both outputs read 0.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,   // bubbles per load-use hazard (1..7)
    parameter int DRAIN_CYCLES      = 3,   // cycles spent in DRAIN before HALTED
    parameter int CNT_W             = 16   // perf counter width
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_read_mem_i,
    input  logic [2:0]       idex_regD_i,
    input  logic [2:0]       ifid_reg1_i,
    input  logic [2:0]       ifid_reg2_i,
    input  logic             ifid_uses_reg2_i,
    input  logic             ifid_halt_i,
    input  logic             branch_taken_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             running_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, HALTED} stateT;

    localparam int MAX_LOAD  = (LOAD_STALL_CYCLES > DRAIN_CYCLES) ? LOAD_STALL_CYCLES : DRAIN_CYCLES;
    localparam int DOWN_W    = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD);
    localparam int DRAIN_TOP = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    stateT             state;
    logic [DOWN_W-1:0] downCnt;
    logic              loadUse;

    assign loadUse = idex_read_mem_i &
                     ((idex_regD_i == ifid_reg1_i) |
                      (ifid_uses_reg2_i & (idex_regD_i == ifid_reg2_i)));

    // Control outputs decoded from the current state and this cycle's hazard inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b1;
        if (!rst_i) begin
            case (state)
                IDLE, HALTED: ifid_flush_o = start_i;
                RUN: begin
                    if (branch_taken_i) begin
                        // The instruction in ID is squashed, so its hazard/HALT is moot.
                        pc_en_o      = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else if (loadUse) begin
                        // Hold PC and IF_ID, feed a bubble into EX.
                    end else if (ifid_halt_i) begin
                        // HALT moves on into ID_EX; nothing behind it is fetched.
                        ifid_flush_o  = 1'b1;
                        idex_bubble_o = 1'b0;
                    end else begin
                        pc_en_o       = 1'b1;
                        ifid_en_o     = 1'b1;
                        idex_bubble_o = 1'b0;
                    end
                end
                default: ;  // STALL and DRAIN keep the frozen defaults
            endcase
        end
    end

    assign running_o = !rst_i && ((state == RUN) || (state == STALL));
    assign halted_o  = !rst_i && (state == HALTED);

    // Sequencer state and the shared stall/drain down-counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state   <= IDLE;
            downCnt <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start_i) state <= RUN;
                end
                RUN: begin
                    if (branch_taken_i) begin
                        state <= RUN;
                    end else if (loadUse) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state   <= STALL;
                            downCnt <= DOWN_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end else if (ifid_halt_i) begin
                        state   <= DRAIN;
                        downCnt <= DOWN_W'(DRAIN_TOP);
                    end
                end
                STALL: begin
                    // The hazard cycle in RUN was the first bubble, so the loaded
                    // count is exactly the number of STALL cycles left.
                    downCnt <= downCnt - DOWN_W'(1);
                    if (downCnt <= DOWN_W'(1)) state <= RUN;
                end
                DRAIN: begin
                    // Count runs down to 0 and HALTED follows one edge later, so
                    // DRAIN lasts DRAIN_CYCLES cycles (EX, MEM, WB).
                    if (downCnt == '0) state <= HALTED;
                    else               downCnt <= downCnt - DOWN_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic             stallEvt;
    logic             flushEvt;

    assign stallEvt = !rst_i && ((state == STALL) ||
                                 ((state == RUN) && !branch_taken_i && loadUse));
    assign flushEvt = !rst_i && (state == RUN) && branch_taken_i;

    // Saturating perf counters: one per bubble cycle, one per taken-branch flush.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallEvt && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
            if (flushEvt && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stallCnt;
    assign flush_cnt_o = flushCnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two controllers (1 and 3 load-use bubbles) share one
// stimulus stream; each is compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, start_i, idex_read_mem_i, ifid_uses_reg2_i, ifid_halt_i, branch_taken_i;
    logic [2:0] idex_regD_i, ifid_reg1_i, ifid_reg2_i;

    logic        pcEnA, ifidEnA, flushA, bubbleA, runA, haltA;
    logic        pcEnB, ifidEnB, flushB, bubbleB, runB, haltB;
    logic [15:0] stallCntA, flushCntA, stallCntB, flushCntB;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(3), .CNT_W(16)) dutA (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .idex_read_mem_i(idex_read_mem_i),
        .idex_regD_i(idex_regD_i), .ifid_reg1_i(ifid_reg1_i), .ifid_reg2_i(ifid_reg2_i),
        .ifid_uses_reg2_i(ifid_uses_reg2_i), .ifid_halt_i(ifid_halt_i),
        .branch_taken_i(branch_taken_i), .pc_en_o(pcEnA), .ifid_en_o(ifidEnA),
        .ifid_flush_o(flushA), .idex_bubble_o(bubbleA), .running_o(runA),
        .halted_o(haltA), .stall_cnt_o(stallCntA), .flush_cnt_o(flushCntA));

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(3), .CNT_W(16)) dutB (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .idex_read_mem_i(idex_read_mem_i),
        .idex_regD_i(idex_regD_i), .ifid_reg1_i(ifid_reg1_i), .ifid_reg2_i(ifid_reg2_i),
        .ifid_uses_reg2_i(ifid_uses_reg2_i), .ifid_halt_i(ifid_halt_i),
        .branch_taken_i(branch_taken_i), .pc_en_o(pcEnB), .ifid_en_o(ifidEnB),
        .ifid_flush_o(flushB), .idex_bubble_o(bubbleB), .running_o(runB),
        .halted_o(haltB), .stall_cnt_o(stallCntB), .flush_cnt_o(flushCntB));

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: "executing" flag, bubbles still owed, drain cycles left,
    // completion flag and the event tallies.
    bit mRun[2];
    bit mHalted[2];
    int mStallLeft[2];
    int mDrainLeft[2];
    int mStallCnt[2];
    int mFlushCnt[2];

    function automatic int bubblesOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit hazard();
        return idex_read_mem_i && ((idex_regD_i == ifid_reg1_i) ||
                                   (ifid_uses_reg2_i && (idex_regD_i == ifid_reg2_i)));
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_bubble, running, halted}
    function automatic logic [5:0] expCtl(input int i);
        logic pc, en, fl, bub;
        pc = 1'b0; en = 1'b0; fl = 1'b0; bub = 1'b1;
        if (rst_i) return 6'b000100;
        if (mStallLeft[i] > 0 || mDrainLeft[i] > 0) begin
            // frozen: defaults
        end else if (mRun[i]) begin
            if (branch_taken_i) begin pc = 1'b1; fl = 1'b1; end
            else if (hazard()) begin end
            else if (ifid_halt_i) begin fl = 1'b1; bub = 1'b0; end
            else begin pc = 1'b1; en = 1'b1; bub = 1'b0; end
        end else begin
            fl = start_i;
        end
        return {pc, en, fl, bub, logic'(mRun[i]), logic'(mHalted[i])};
    endfunction

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic updModel(input int i);
        if (rst_i) begin
            mRun[i] = 0; mHalted[i] = 0; mStallLeft[i] = 0; mDrainLeft[i] = 0;
            mStallCnt[i] = 0; mFlushCnt[i] = 0;
        end else if (mStallLeft[i] > 0) begin
            mStallCnt[i] = sat(mStallCnt[i]);
            mStallLeft[i]--;
        end else if (mDrainLeft[i] > 0) begin
            mDrainLeft[i]--;
            if (mDrainLeft[i] == 0) mHalted[i] = 1;
        end else if (mRun[i]) begin
            if (branch_taken_i) mFlushCnt[i] = sat(mFlushCnt[i]);
            else if (hazard()) begin
                mStallCnt[i]  = sat(mStallCnt[i]);
                mStallLeft[i] = bubblesOf(i) - 1;
            end else if (ifid_halt_i) begin
                mRun[i]       = 0;
                mDrainLeft[i] = 3;
            end
        end else if (start_i) begin
            mRun[i] = 1; mHalted[i] = 0;
        end
    endtask

    task automatic checkDut(input int i);
        logic [5:0]  ctl;
        logic [15:0] sc, fc;
        int          expS, expF;
        ctl = (i == 0) ? {pcEnA, ifidEnA, flushA, bubbleA, runA, haltA}
                       : {pcEnB, ifidEnB, flushB, bubbleB, runB, haltB};
        sc  = (i == 0) ? stallCntA : stallCntB;
        fc  = (i == 0) ? flushCntA : flushCntB;
`ifdef PIPE_PERF_CNT_EN
        expS = mStallCnt[i];
        expF = mFlushCnt[i];
`else
        expS = 0;
        expF = 0;
`endif
        check($sformatf("ctl[%0d] {pc,en,fl,bub,run,halt}", i), 32'(ctl), 32'(expCtl(i)));
        check($sformatf("stall_cnt[%0d]", i), 32'(sc), 32'(expS));
        check($sformatf("flush_cnt[%0d]", i), 32'(fc), 32'(expF));
    endtask

    // Drive one cycle of inputs, check both DUTs mid-cycle, advance the models at the edge.
    task automatic cycle(input logic r, input logic s, input logic rm, input logic [2:0] rd,
                         input logic [2:0] r1, input logic [2:0] r2, input logic u2,
                         input logic h, input logic b);
        @(negedge clk);
        rst_i = r; start_i = s; idex_read_mem_i = rm; idex_regD_i = rd;
        ifid_reg1_i = r1; ifid_reg2_i = r2; ifid_uses_reg2_i = u2;
        ifid_halt_i = h; branch_taken_i = b;
        #1;
        for (int i = 0; i < 2; i++) checkDut(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) updModel(i);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 1, 2, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; idex_read_mem_i = 1'b0; idex_regD_i = '0;
        ifid_reg1_i = '0; ifid_reg2_i = '0; ifid_uses_reg2_i = 1'b0;
        ifid_halt_i = 1'b0; branch_taken_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mRun[i] = 0; mHalted[i] = 0; mStallLeft[i] = 0; mDrainLeft[i] = 0;
            mStallCnt[i] = 0; mFlushCnt[i] = 0;
        end
        // Unchecked first edge brings the flops out of their power-up X state.
        @(posedge clk);

        // Reset held 3 cycles, one idle cycle, then start.
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // LOAD r3 then ADD r1,r3: one bubble on A, three on B.
        cycle(0, 0, 1, 3, 3, 1, 1, 0, 0);
        idle(3);

        // Match on reg2 only: no stall when reg2 is unused, stall when it is.
        cycle(0, 0, 1, 5, 1, 5, 0, 0, 0);
        cycle(0, 0, 1, 5, 1, 5, 1, 0, 0);
        idle(3);

        // Taken branch together with a load-use hazard and HALT: flush only.
        cycle(0, 0, 1, 2, 2, 2, 1, 1, 1);
        idle(1);

        // HALT -> DRAIN; branch and start during drain are ignored; then restart.
        cycle(0, 0, 0, 0, 1, 2, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 2, 0, 0, 1);
        cycle(0, 1, 0, 0, 1, 2, 0, 0, 0);
        idle(3);
        cycle(0, 1, 0, 0, 1, 2, 0, 0, 0);
        idle(1);

        // Reset while B sits in STALL.
        cycle(0, 0, 1, 4, 4, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 2, 0, 0, 0);
        idle(1);
        cycle(0, 1, 0, 0, 1, 2, 0, 0, 0);

        // Reset in the middle of DRAIN.
        cycle(0, 0, 0, 0, 1, 2, 0, 1, 0);
        idle(1);
        cycle(1, 0, 0, 0, 1, 2, 0, 0, 0);
        idle(2);
        cycle(0, 1, 0, 0, 1, 2, 0, 0, 0);

        // Randomised traffic with biased event rates.
        for (int n = 0; n < 2000; n++) begin
            cycle(logic'($urandom_range(0, 199) == 0),
                  logic'($urandom_range(0, 9) == 0),
                  logic'($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 24) == 0),
                  logic'($urandom_range(0, 6) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
